alu_uart_interface: RTL and testbench

ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

---
 rtl/alu_uart_interface.sv | 138 +++++++++++++
 tb/tb_alu_uart_interface.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// Frame sequencer between a UART and an ALU: collects A, B, opcode bytes,
// runs the ALU for one cycle and hands the result byte to the UART TX.
//
// Ports:
//   i_clock, i_reset       clock, async active-high reset
//   i_rx_done, i_rx_data   received byte strobe and data
//   i_alu_result           combinational ALU result for o_data_a/b, o_op
//   i_tx_done              TX byte finished
//   o_data_a, o_data_b     registered operands
//   o_op                   registered opcode (low NB_OP bits of op byte)
//   o_tx_data, o_tx_start  result byte and one-cycle start pulse to TX
//   o_busy                 high in EXEC, SEND, WAIT_TX
//   o_timeout, o_overrun   one-cycle event pulses
module alu_uart_interface #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 200000
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_rx_done,
    input  logic [DBIT-1:0] i_rx_data,
    input  logic [DBIT-1:0] i_alu_result,
    input  logic            i_tx_done,
    output logic [DBIT-1:0] o_data_a,
    output logic [DBIT-1:0] o_data_b,
    output logic [NB_OP-1:0] o_op,
    output logic [DBIT-1:0] o_tx_data,
    output logic            o_tx_start,
    output logic            o_busy,
    output logic            o_timeout,
    output logic            o_overrun
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] idle_cnt, idle_next;
    logic          in_frame, busy_st, expired;
    logic          ld_a, ld_b, ld_op, ld_tx;
    logic          timeout_next, overrun_next, busy_next;

    always_comb begin
        state_next   = state;
        idle_next    = idle_cnt;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_op        = 1'b0;
        ld_tx        = 1'b0;
        timeout_next = 1'b0;

        in_frame = (state == WAIT_B) || (state == WAIT_OP);
        busy_st  = state inside {EXEC, SEND, WAIT_TX};
        // A byte landing on the last idle cycle wins over the timeout.
        expired  = in_frame && !i_rx_done && (idle_cnt == CNT_LAST);
        overrun_next = i_rx_done && busy_st;

        unique case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    ld_a       = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    ld_b       = 1'b1;
                    state_next = WAIT_OP;
                end else if (expired) begin
                    timeout_next = 1'b1;
                    state_next   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    ld_op      = 1'b1;
                    state_next = EXEC;
                end else if (expired) begin
                    timeout_next = 1'b1;
                    state_next   = WAIT_A;
                end
            end
            EXEC: begin
                ld_tx      = 1'b1;
                state_next = SEND;
            end
            SEND: state_next = WAIT_TX;
            WAIT_TX: begin
                if (i_tx_done) state_next = WAIT_A;
            end
            default: state_next = WAIT_A;
        endcase

        // Leaving at CNT_LAST guarantees the counter never wraps.
        if (state_next != state) idle_next = '0;
        else if (in_frame)       idle_next = idle_cnt + 1'b1;

        // Registered outputs mirror the state they will be in next cycle.
        busy_next = state_next inside {EXEC, SEND, WAIT_TX};
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= WAIT_A;
            idle_cnt   <= '0;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_next;
            idle_cnt   <= idle_next;
            o_tx_start <= (state_next == SEND);
            o_busy     <= busy_next;
            o_timeout  <= timeout_next;
            o_overrun  <= overrun_next;
            if (ld_a)  o_data_a  <= i_rx_data;
            if (ld_b)  o_data_b  <= i_rx_data;
            if (ld_op) o_op      <= i_rx_data[NB_OP-1:0];
            if (ld_tx) o_tx_data <= i_alu_result;
        end
    end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface: frame table plus timeout,
// overrun and reset corner sequences with a small reference ALU.
module tb_alu_uart_interface;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] alu_res;
    logic       tx_done;
    logic [7:0] data_a, data_b, tx_data;
    logic [5:0] op;
    logic       tx_start, busy, tout, ovr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_uart_interface #(.DBIT(8), .NB_OP(6), .TIMEOUT(TO)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_rx_done(rx_done),
        .i_rx_data(rx_data),
        .i_alu_result(alu_res),
        .i_tx_done(tx_done),
        .o_data_a(data_a),
        .o_data_b(data_b),
        .o_op(op),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .o_busy(busy),
        .o_timeout(tout),
        .o_overrun(ovr)
    );

    // External ALU the interface drives.
    always_comb begin
        case (op)
            6'h20:   alu_res = data_a + data_b;
            6'h22:   alu_res = data_a - data_b;
            6'h24:   alu_res = data_a & data_b;
            6'h25:   alu_res = data_a | data_b;
            6'h26:   alu_res = data_a ^ data_b;
            default: alu_res = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_byte;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic finish_tx();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("idle_after_tx", {31'd0, busy}, 32'd0);
    endtask

    // Sends the op byte and follows EXEC, SEND into WAIT_TX.
    task automatic op_and_result(input logic [7:0] ob, input logic [5:0] eop,
                                 input logic [7:0] eres);
        send_byte(ob);
        check("exec_start", {31'd0, tx_start}, 32'd0);
        check("exec_busy", {31'd0, busy}, 32'd1);
        check("op", {26'd0, op}, {26'd0, eop});
        @(negedge clk);
        check("send_start", {31'd0, tx_start}, 32'd1);
        check("tx_data", {24'd0, tx_data}, {24'd0, eres});
        @(negedge clk);
        check("wtx_start", {31'd0, tx_start}, 32'd0);
        check("wtx_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ob, input logic [5:0] eop,
                         input logic [7:0] eres);
        send_byte(a);
        send_byte(b);
        check("data_a", {24'd0, data_a}, {24'd0, a});
        check("data_b", {24'd0, data_b}, {24'd0, b});
        op_and_result(ob, eop, eres);
        finish_tx();
    endtask

    initial begin
        vecs[0] = '{8'h55, 8'h01, 8'h20, 6'h20, 8'h56};
        vecs[1] = '{8'h10, 8'h20, 8'hE0, 6'h20, 8'h30};
        vecs[2] = '{8'h0F, 8'h05, 8'h22, 6'h22, 8'h0A};
        vecs[3] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
        vecs[4] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
        vecs[5] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55};
        vecs[6] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
        vecs[7] = '{8'h03, 8'h05, 8'hA2, 6'h22, 8'hFE};

        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outs",
              {data_a, data_b, tx_data, 2'b00, op},
              32'd0);
        check("rst_flags", {28'd0, tx_start, busy, tout, ovr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            frame(vecs[i].a, vecs[i].b, vecs[i].op_byte,
                  vecs[i].exp_op, vecs[i].exp_res);

        // Stray tx_done outside WAIT_TX.
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray_tx_done", {31'd0, busy}, 32'd0);

        // Timeout abandon in WAIT_B.
        send_byte(8'h11);
        repeat (TO - 1) @(negedge clk);
        check("to_early", {31'd0, tout}, 32'd0);
        @(negedge clk);
        check("to_pulse", {31'd0, tout}, 32'd1);
        @(negedge clk);
        check("to_clear", {31'd0, tout}, 32'd0);
        check("to_keep_a", {24'd0, data_a}, 32'h11);
        frame(8'h02, 8'h03, 8'h20, 6'h20, 8'h05);

        // Byte on the timeout cycle is accepted.
        send_byte(8'h11);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h22);
        check("bnd_no_to", {31'd0, tout}, 32'd0);
        check("bnd_b", {24'd0, data_b}, 32'h22);
        @(negedge clk);
        check("bnd_no_to2", {31'd0, tout}, 32'd0);
        op_and_result(8'h20, 6'h20, 8'h33);
        finish_tx();

        // Overrun during WAIT_TX.
        send_byte(8'h40);
        send_byte(8'h02);
        op_and_result(8'h20, 6'h20, 8'h42);
        send_byte(8'h7F);
        check("ovr_pulse", {31'd0, ovr}, 32'd1);
        check("ovr_tx_data", {24'd0, tx_data}, 32'h42);
        check("ovr_a", {24'd0, data_a}, 32'h40);
        @(negedge clk);
        check("ovr_clear", {31'd0, ovr}, 32'd0);
        finish_tx();
        frame(8'h01, 8'h01, 8'h20, 6'h20, 8'h02);

        // Reset mid-frame.
        send_byte(8'h12);
        send_byte(8'h34);
        rst = 1'b1;
        #1;
        check("mid_rst_outs",
              {data_a, data_b, tx_data, 2'b00, op},
              32'd0);
        check("mid_rst_flags", {28'd0, tx_start, busy, tout, ovr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame(8'h05, 8'h06, 8'h20, 6'h20, 8'h0B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
